// File: rtl/alu_seq_unit_pkg.sv
// Shared opcode encodings and FSM state type for the sequential ALU.
package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_LSH  = 4'h2;
  localparam logic [3:0] OP_RSH  = 4'h3;
  localparam logic [3:0] OP_XOR  = 4'h4;
  localparam logic [3:0] OP_CMP  = 4'h5;
  localparam logic [3:0] OP_AND  = 4'h6;
  localparam logic [3:0] OP_NAND = 4'h7;
  localparam logic [3:0] OP_OR   = 4'h8;
  localparam logic [3:0] OP_NOR  = 4'h9;
  localparam logic [3:0] OP_MUL  = 4'hA;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

endpackage

// File: rtl/alu_seq_unit_if.sv
// Issue/result handshake bundle between the issue stage, the ALU and writeback.
interface alu_seq_unit_if #(parameter int WIDTH = 8);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] opA;
  logic [WIDTH-1:0] opB;
  logic [3:0]       opcode;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] outQ;
  logic [WIDTH-1:0] outH;
  logic             cout;
  logic             flag_z;
  logic             flag_n;
  logic             flag_v;

  modport slave (
    input  in_valid, opA, opB, opcode, cin, out_ready,
    output in_ready, out_valid, outQ, outH, cout, flag_z, flag_n, flag_v
  );

  modport master (
    output in_valid, opA, opB, opcode, cin, out_ready,
    input  in_ready, out_valid, outQ, outH, cout, flag_z, flag_n, flag_v
  );
endinterface

// File: rtl/alu_seq_unit_mul.sv
// Iterative unsigned shift-add multiplier: start loads operands, WIDTH busy
// cycles follow; done is high in the last one with the final product on prod_o.
module alu_mul_iter #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [2*WIDTH-1:0] prod_o
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [2*WIDTH-1:0] mcand_q, mcand_d, acc_q, acc_d, acc_step;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               busy_q, busy_d;

  // prod_o already includes the iteration performed on the done edge
  assign acc_step = mplier_q[0] ? acc_q + mcand_q : acc_q;
  assign done_o   = busy_q && (cnt_q == LAST);
  assign busy_o   = busy_q;
  assign prod_o   = acc_step;

  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    if (start_i) begin
      mcand_d  = {{WIDTH{1'b0}}, a_i};
      mplier_d = b_i;
      acc_d    = '0;
      cnt_d    = '0;
      busy_d   = 1'b1;
    end else if (busy_q) begin
      acc_d    = acc_step;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + 1'b1;
      if (done_o) busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
    end
  end
endmodule

// File: rtl/alu_seq_unit.sv
// Registered ALU with valid/ready handshakes and an iterative MUL.
// Define ALU_FLAGS_EN to register Z/N/V flags with the result (else tied to 0).
module alu_seq_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  alu_seq_unit_if.slave  bus
);
  localparam int MSB = WIDTH - 1;

  state_t             state_q, state_d;
  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   outQ_q, outQ_d, outH_q, outH_d;
  logic               cout_q, cout_d;
  logic               accept, mul_start, mul_busy, mul_done;
  logic [2*WIDTH-1:0] mul_prod;
  logic [WIDTH:0]     sum;
  logic [WIDTH-1:0]   alu_q;
  logic               alu_c;

  assign bus.in_ready = (state_q != ST_MUL) && !mul_busy && (!out_valid_q || bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (mul_start),
    .a_i     (bus.opA),
    .b_i     (bus.opB),
    .busy_o  (mul_busy),
    .done_o  (mul_done),
    .prod_o  (mul_prod)
  );

  always_comb begin
    sum   = '0;
    alu_q = '0;
    alu_c = 1'b0;
    unique case (bus.opcode)
      OP_ADD: begin
        sum   = {1'b0, bus.opA} + {1'b0, bus.opB} + {{WIDTH{1'b0}}, bus.cin};
        alu_q = sum[MSB:0];
        alu_c = sum[WIDTH];
      end
      OP_SUB: begin
        sum   = {1'b0, bus.opA} + {1'b0, ~bus.opB} + {{WIDTH{1'b0}}, bus.cin};
        alu_q = sum[MSB:0];
        alu_c = sum[WIDTH];
      end
      OP_LSH: begin
        alu_q = {bus.opA[MSB-1:0], bus.cin};
        alu_c = bus.opA[MSB];
      end
      OP_RSH: begin
        alu_q = {bus.cin, bus.opA[MSB:1]};
        alu_c = bus.opA[0];
      end
      OP_XOR:  alu_q = bus.opA ^ bus.opB;
      OP_AND:  alu_q = bus.opA & bus.opB;
      OP_NAND: alu_q = ~(bus.opA & bus.opB);
      OP_OR:   alu_q = bus.opA | bus.opB;
      OP_NOR:  alu_q = ~(bus.opA | bus.opB);
      OP_CMP:  alu_q = (bus.opA == bus.opB) ? WIDTH'(1) :
                       (bus.opA >  bus.opB) ? WIDTH'(2) : WIDTH'(3);
      default: alu_q = '0;
    endcase
  end

`ifdef ALU_FLAGS_EN
  logic alu_v, fz_q, fz_d, fn_q, fn_d, fv_q, fv_d;

  always_comb begin
    alu_v = 1'b0;
    if (bus.opcode == OP_ADD)
      alu_v = (bus.opA[MSB] == bus.opB[MSB]) && (sum[MSB] != bus.opA[MSB]);
    else if (bus.opcode == OP_SUB)
      alu_v = (bus.opA[MSB] != bus.opB[MSB]) && (sum[MSB] != bus.opA[MSB]);
  end
`endif

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q && !bus.out_ready;
    outQ_d      = outQ_q;
    outH_d      = outH_q;
    cout_d      = cout_q;
    mul_start   = 1'b0;
`ifdef ALU_FLAGS_EN
    fz_d = fz_q;
    fn_d = fn_q;
    fv_d = fv_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (accept && bus.opcode == OP_MUL) begin
          mul_start = 1'b1;
          state_d   = ST_MUL;
        end else if (accept) begin
          outQ_d      = alu_q;
          outH_d      = '0;
          cout_d      = alu_c;
          out_valid_d = 1'b1;
`ifdef ALU_FLAGS_EN
          fz_d = (alu_q == '0);
          fn_d = alu_q[MSB];
          fv_d = alu_v;
`endif
        end
      end
      ST_MUL: begin
        if (mul_done) begin
          outQ_d      = mul_prod[MSB:0];
          outH_d      = mul_prod[2*WIDTH-1:WIDTH];
          cout_d      = 1'b0;
          out_valid_d = 1'b1;
          state_d     = ST_IDLE;
`ifdef ALU_FLAGS_EN
          fz_d = (mul_prod[MSB:0] == '0);
          fn_d = mul_prod[MSB];
          fv_d = 1'b0;
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      outQ_q      <= '0;
      outH_q      <= '0;
      cout_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      outQ_q      <= outQ_d;
      outH_q      <= outH_d;
      cout_q      <= cout_d;
    end
  end

`ifdef ALU_FLAGS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fz_q <= 1'b0;
      fn_q <= 1'b0;
      fv_q <= 1'b0;
    end else begin
      fz_q <= fz_d;
      fn_q <= fn_d;
      fv_q <= fv_d;
    end
  end

  assign bus.flag_z = fz_q;
  assign bus.flag_n = fn_q;
  assign bus.flag_v = fv_q;
`else
  assign bus.flag_z = 1'b0;
  assign bus.flag_n = 1'b0;
  assign bus.flag_v = 1'b0;
`endif

  assign bus.out_valid = out_valid_q;
  assign bus.outQ      = outQ_q;
  assign bus.outH      = outH_q;
  assign bus.cout      = cout_q;
endmodule

// File: tb/tb_alu_seq_unit.sv
// Self-checking bench for alu_seq_unit: directed cases and random ops on an
// 8-bit unit, plus a back-to-back stream on a 16-bit unit.
module tb_alu_seq_unit;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_seq_unit_if #(.WIDTH(8))  b8 ();
  alu_seq_unit_if #(.WIDTH(16)) b16 ();

  alu_seq_unit #(.WIDTH(8))  u8  (.clk(clk), .rst_n(rst_n), .bus(b8.slave));
  alu_seq_unit #(.WIDTH(16)) u16 (.clk(clk), .rst_n(rst_n), .bus(b16.slave));

  int vecs = 0;
  int errs = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecs++;
    assert (obs === exp)
    else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: arithmetic straight from the opcode definitions, signed overflow by range test
  function automatic void model(input int unsigned w, input logic [3:0] op,
                                input longint unsigned a, input longint unsigned b, input bit c,
                                output longint unsigned q, output longint unsigned h,
                                output bit co, output bit fz, output bit fn, output bit fv);
    longint unsigned m, s;
    longint sa, sb, sr, lo, hi;
    m  = (64'd1 << w) - 64'd1;
    lo = -(longint'(1) << (w - 1));
    hi = (longint'(1) << (w - 1)) - 1;
    sa = a[w-1] ? longint'(a) - longint'(m) - 1 : longint'(a);
    sb = b[w-1] ? longint'(b) - longint'(m) - 1 : longint'(b);
    s = 0; sr = 0;
    q = 0; h = 0; co = 1'b0; fv = 1'b0;
    case (op)
      4'h0: begin s = a + b + 64'(c); q = s & m; co = s[w];
                  sr = sa + sb + longint'(c); fv = (sr < lo) || (sr > hi); end
      4'h1: begin s = a + (~b & m) + 64'(c); q = s & m; co = s[w];
                  sr = sa - sb - (1 - longint'(c)); fv = (sr < lo) || (sr > hi); end
      4'h2: begin q = ((a << 1) | 64'(c)) & m; co = a[w-1]; end
      4'h3: begin q = (64'(c) << (w - 1)) | (a >> 1); co = a[0]; end
      4'h4: q = a ^ b;
      4'h5: q = (a == b) ? 64'd1 : (a > b) ? 64'd2 : 64'd3;
      4'h6: q = a & b;
      4'h7: q = ~(a & b) & m;
      4'h8: q = a | b;
      4'h9: q = ~(a | b) & m;
      4'hA: begin s = a * b; q = s & m; h = s >> w; end
      default: q = 0;
    endcase
    fz = (q == 0);
    fn = q[w-1];
`ifndef ALU_FLAGS_EN
    fz = 1'b0; fn = 1'b0; fv = 1'b0;
`endif
  endfunction

  task automatic run8(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                      input logic c, input string tag);
    longint unsigned q, h;
    bit co, fz, fn, fv;
    int lat, busy;
    model(8, op, 64'(a), 64'(b), c, q, h, co, fz, fn, fv);
    @(negedge clk);
    b8.in_valid = 1'b1; b8.opA = a; b8.opB = b; b8.opcode = op; b8.cin = c;
    b8.out_ready = 1'b0;
    chk({tag, ".rdy"}, 64'(b8.in_ready), 64'd1);
    @(posedge clk); #1;
    b8.in_valid = 1'b0;
    lat = 1; busy = 0;
    while (!b8.out_valid && lat < 40) begin
      if (!b8.in_ready) busy++;
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, ".lat"},  64'(lat),  (op == OP_MUL) ? 64'd9 : 64'd1);
    chk({tag, ".busy"}, 64'(busy), (op == OP_MUL) ? 64'd8 : 64'd0);
    chk({tag, ".q"},    64'(b8.outQ), q);
    chk({tag, ".h"},    64'(b8.outH), h);
    chk({tag, ".c"},    64'(b8.cout), 64'(co));
    chk({tag, ".flg"},  64'({b8.flag_z, b8.flag_n, b8.flag_v}), 64'({fz, fn, fv}));
    @(negedge clk); b8.out_ready = 1'b1;
    @(posedge clk); #1;
    b8.out_ready = 1'b0;
    chk({tag, ".drain"}, 64'(b8.out_valid), 64'd0);
  endtask

  initial begin
    longint unsigned q, h;
    bit co, fz, fn, fv;
    logic [3:0]  op;
    logic [15:0] a16, b16v;
    logic        c;

    b8.in_valid = 1'b0; b8.opA = '0; b8.opB = '0; b8.opcode = '0; b8.cin = 1'b0; b8.out_ready = 1'b0;
    b16.in_valid = 1'b0; b16.opA = '0; b16.opB = '0; b16.opcode = '0; b16.cin = 1'b0; b16.out_ready = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst.valid", 64'(b8.out_valid), 64'd0);
    chk("rst.rdy",   64'(b8.in_ready),  64'd1);
    chk("rst.outs",  64'({b8.outQ, b8.outH, b8.cout, b8.flag_z, b8.flag_n, b8.flag_v}), 64'd0);
    rst_n = 1'b1;

    run8(OP_ADD, 8'hFF, 8'h01, 1'b0, "add_wrap");
    run8(OP_SUB, 8'h05, 8'h07, 1'b1, "sub_borrow");
    run8(OP_CMP, 8'h05, 8'h07, 1'b0, "cmp_lt");
    run8(OP_CMP, 8'h42, 8'h42, 1'b0, "cmp_eq");
    run8(OP_ADD, 8'h7F, 8'h01, 1'b0, "add_ovf");
    run8(OP_LSH, 8'h81, 8'h00, 1'b1, "lsh");
    run8(OP_RSH, 8'h81, 8'h00, 1'b1, "rsh");
    run8(OP_MUL, 8'hFF, 8'hFF, 1'b1, "mul_max");
    run8(OP_MUL, 8'h00, 8'h5A, 1'b0, "mul_zero");
    run8(4'hD,   8'h12, 8'h34, 1'b1, "undef_op");

    // Hold result with out_ready low, then drain and accept in the same cycle
    @(negedge clk);
    b8.in_valid = 1'b1; b8.opA = 8'hFF; b8.opB = 8'h01; b8.opcode = OP_ADD; b8.cin = 1'b0;
    b8.out_ready = 1'b0;
    @(posedge clk); #1;
    b8.opA = 8'h05; b8.opB = 8'h07; b8.opcode = OP_SUB; b8.cin = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold.valid", 64'(b8.out_valid), 64'd1);
      chk("hold.rdy",   64'(b8.in_ready),  64'd0);
      chk("hold.q",     64'({b8.outQ, b8.cout}), 64'h001);
    end
    b8.out_ready = 1'b1;
    #1 chk("b2b.rdy", 64'(b8.in_ready), 64'd1);
    @(posedge clk); #1;
    b8.in_valid = 1'b0;
    chk("b2b.valid", 64'(b8.out_valid), 64'd1);
    chk("b2b.q",     64'({b8.outQ, b8.cout}), 64'h1FC);
    @(posedge clk); #1;
    b8.out_ready = 1'b0;
    chk("b2b.drain", 64'(b8.out_valid), 64'd0);

    // Reset during the fourth MUL cycle abandons the product
    @(negedge clk);
    b8.in_valid = 1'b1; b8.opA = 8'hC3; b8.opB = 8'h3C; b8.opcode = OP_MUL; b8.out_ready = 1'b1;
    @(posedge clk); #1;
    b8.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mrst.valid", 64'(b8.out_valid), 64'd0);
    chk("mrst.rdy",   64'(b8.in_ready),  64'd1);
    chk("mrst.q",     64'({b8.outQ, b8.outH}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) begin
      @(posedge clk); #1;
      chk("mrst.noresult", 64'(b8.out_valid), 64'd0);
    end
    b8.out_ready = 1'b0;
    run8(OP_ADD, 8'h10, 8'h20, 1'b1, "add_after_rst");

    for (int i = 0; i < 30; i++) begin
      run8(4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom), 1'($urandom), "rand8");
    end

    // 16-bit stream: one op per cycle, each result must match the op just issued
    b16.out_ready = 1'b1;
    for (int i = 0; i < 60; i++) begin
      op = 4'($urandom_range(0, 14));
      if (op >= OP_MUL) op = op + 4'd1;
      a16 = 16'($urandom); b16v = 16'($urandom); c = 1'($urandom);
      if (i == 0) begin a16 = 16'hFFFF; b16v = 16'h0001; op = OP_ADD; c = 1'b0; end
      model(16, op, 64'(a16), 64'(b16v), c, q, h, co, fz, fn, fv);
      @(negedge clk);
      chk("s16.rdy", 64'(b16.in_ready), 64'd1);
      b16.in_valid = 1'b1; b16.opA = a16; b16.opB = b16v; b16.opcode = op; b16.cin = c;
      @(posedge clk); #1;
      chk("s16.valid", 64'(b16.out_valid), 64'd1);
      chk("s16.q",     64'(b16.outQ), q);
      chk("s16.hc",    64'({b16.outH, b16.cout}), {h[47:0], 15'd0, co});
      chk("s16.flg",   64'({b16.flag_z, b16.flag_n, b16.flag_v}), 64'({fz, fn, fv}));
    end
    @(negedge clk);
    b16.in_valid = 1'b0;
    @(posedge clk); #1;
    chk("s16.end", 64'(b16.out_valid), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
